// File: rtl/adder_tree_pipe.sv
// Pipelined N-input signed adder tree with optional
// saturation and optional per-group accumulation.
module adder_tree_pipe #(
  parameter int NUM       = 4,
  parameter int WIDTH     = 32,
  parameter int SAT       = 1,
  parameter int ACC       = 0,
  parameter int ACC_GUARD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM*WIDTH-1:0] i,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic [WIDTH-1:0]     o,
  output logic                 o_valid,
  output logic                 o_ovf
);

  localparam int LVL = $clog2(NUM);
  localparam int TW  = WIDTH + LVL;
  localparam int AW  = TW + ACC_GUARD;
  localparam int FW  = (ACC != 0) ? AW : TW;

  function automatic int cnt(int l);
    int c;
    c = NUM;
    for (int k = 0; k < l; k++) c = (c + 1) / 2;
    return c;
  endfunction

  logic [LVL-1:0] vq;
  logic [LVL-1:0] lq;
  logic [LVL:0]   vs;
  logic [LVL:0]   ls;

  assign vs = {vq, i_valid};
  assign ls = {lq, i_valid & i_last};

  // valid/last flags travel alongside the tree data
  always_ff @(posedge clk) begin
    if (!rst) begin
      vq <= '0;
      lq <= '0;
    end else begin
      vq <= vs[LVL-1:0];
      lq <= ls[LVL-1:0];
    end
  end

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int C = cnt(l);
    logic [WIDTH+l-1:0] s [C];
    if (l == 0) begin : g_in
      for (genvar j = 0; j < C; j++) begin : g_op
        assign s[j] = i[j*WIDTH +: WIDTH];
      end
    end else begin : g_reg
      localparam int P = cnt(l - 1);
      for (genvar j = 0; j < C; j++) begin : g_node
        if (2*j + 1 < P) begin : g_add
          // pairwise sum, one bit of growth
          always_ff @(posedge clk)
            s[j] <= {g_lvl[l-1].s[2*j][WIDTH+l-2],
                     g_lvl[l-1].s[2*j]}
                  + {g_lvl[l-1].s[2*j+1][WIDTH+l-2],
                     g_lvl[l-1].s[2*j+1]};
        end else begin : g_pass
          // odd leftover entry rides through unchanged
          always_ff @(posedge clk)
            s[j] <= {g_lvl[l-1].s[2*j][WIDTH+l-2],
                     g_lvl[l-1].s[2*j]};
        end
      end
    end
  end

  logic [TW-1:0] sum_t;
  logic          tree_v;
  logic          tree_l;
  logic [FW-1:0] full;
  logic          full_v;

  assign sum_t  = g_lvl[LVL].s[0];
  assign tree_v = vq[LVL-1];
  assign tree_l = lq[LVL-1];

  if (ACC != 0) begin : g_acc
    logic [AW-1:0] acc;
    logic [AW-1:0] ext;
    logic [AW-1:0] nxt;
    logic [AW-1:0] sum_a;
    logic          v_a;

    assign ext = AW'($signed(sum_t));
    assign nxt = acc + ext;

    // fold beats into acc; emit and clear on last
    always_ff @(posedge clk) begin
      if (!rst) begin
        acc <= '0;
        v_a <= 1'b0;
      end else begin
        v_a <= tree_v & tree_l;
        if (tree_v) begin
          sum_a <= nxt;
          acc   <= tree_l ? '0 : nxt;
        end
      end
    end

    assign full   = sum_a;
    assign full_v = v_a;
  end else begin : g_dir
    assign full   = sum_t;
    assign full_v = tree_v;
  end

  logic             ovf;
  logic [WIDTH-1:0] sat_v;

  assign ovf   = ~(&full[FW-1:WIDTH-1] | ~|full[FW-1:WIDTH-1]);
  assign sat_v = full[FW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};

  // output register: clamp or wrap, flag out-of-range
  always_ff @(posedge clk) begin
    if (!rst) begin
      o       <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= full_v;
      o_ovf   <= full_v & ovf;
      if (full_v)
        o <= (SAT != 0 && ovf) ? sat_v : full[WIDTH-1:0];
    end
  end

endmodule
